// File: rtl/seqgen_pkg.sv
// seqgen_pkg: shared types and helpers for the seqgen_ser serial transmitter.
//   state_e   : serializer FSM states (IDLE, SHIFT)
//   WIDTH_DEF : default bits per word
//   DEPTH_DEF : default FIFO entries
//   clog2     : ceiling log2, never less than 1, for pointer/bit-index widths
package seqgen_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // Returns at least 1 so a degenerate size still yields a legal vector width.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seqgen_fifo.sv
// seqgen_fifo: circular FIFO feeding the serializer.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (pointers and count only)
//   push_i  : write din_i this edge (ignored while full)
//   din_i   : write data
//   pop_i   : retire the head entry this edge (ignored while empty)
//   head_o  : oldest entry, valid while !empty_o
//   full_o  : count == DEPTH
//   empty_o : count == 0
//   count_o : number of stored entries, 0..DEPTH
module seqgen_fifo
  import seqgen_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Head is read straight from storage, so a word written this edge is
  // only visible (and poppable) from the next edge on: no bypass path.
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap by plain overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; stale contents are harmless once count is 0.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/seqgen_ser.sv
// seqgen_ser: serial byte transmitter. Words enter through a valid/ready
// handshake into a small FIFO and leave MSB-first, one bit per clock, with
// no idle gap between consecutive words.
//   Clk       : clock
//   Reset_n   : asynchronous active-low reset
//   Din       : word to transmit          Din_valid : Din valid this cycle
//   Din_ready : FIFO not full             Pause     : freeze shifting
//   Out       : serial data, MSB first    Bit_valid : Out carries a data bit
//   Last_bit  : Out carries bit 0         Busy      : FIFO non-empty or shifting
//   Sent_cnt  : completed words, wraps
module seqgen_ser
  import seqgen_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  output logic             Din_ready,
  input  logic             Pause,
  output logic             Out,
  output logic             Bit_valid,
  output logic             Last_bit,
  output logic             Busy,
  output logic [CNT_W-1:0] Sent_cnt
);

  localparam int AW = clog2(DEPTH);
  localparam int BW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitidx_q, bitidx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full, fifo_empty;
  logic [AW:0]      fifo_count;
  logic             load, word_done;

  seqgen_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (Din_valid),
    .din_i   (Din),
    .pop_i   (load),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A word finishes on the edge that retires bit 0; the next word is loaded
  // on that same edge when one is waiting, which keeps the stream gapless.
  assign word_done = (state_q == SHIFT) && !Pause && (bitidx_q == '0);
  assign load      = !Pause && !fifo_empty && ((state_q == IDLE) || (bitidx_q == '0));

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitidx_d = bitidx_q;
    cnt_d    = cnt_q;
    if (word_done) cnt_d = cnt_q + 1'b1;
    if (load) begin
      shreg_d  = fifo_head;
      bitidx_d = BW'(WIDTH - 1);
      state_d  = SHIFT;
    end else if ((state_q == SHIFT) && !Pause) begin
      if (bitidx_q != '0) begin
        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
        bitidx_d = bitidx_q - 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      bitidx_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      bitidx_q <= bitidx_d;
      cnt_q    <= cnt_d;
    end
  end

  // Shift data is never observed outside SHIFT, so it needs no reset.
  always_ff @(posedge Clk) begin
    shreg_q <= shreg_d;
  end

  // Out is gated by the registered state, so an asserted reset forces it low
  // at once, while Pause holds state and shreg and therefore holds Out.
  assign Out       = (state_q == SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
  assign Bit_valid = (state_q == SHIFT) && !Pause;
  assign Last_bit  = (state_q == SHIFT) && (bitidx_q == '0);
  assign Busy      = (fifo_count != '0) || (state_q == SHIFT);
  assign Din_ready = !fifo_full;
  assign Sent_cnt  = cnt_q;

endmodule
